pdh_frame_core: RTL and testbench

- Parametrised successor to the PDH command/IQ core.
- Decodes strobed PS GPIO commands; each command executes exactly once per strobe edge.
- Converts two offset-binary ADC channels to signed and rotates them through a pipelined IQ rotator with shadow/active coefficients.
- Streams decimated, length-bounded frames of {I, Q, cos, sin} to the DMA over an AXI-Stream-style valid/ready interface, with overflow accounting.

---
 rtl/pdh_frame_core.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pdh_frame_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdh_frame_core.sv
// pdh_frame_core: strobed PS command decoder, pipelined IQ rotator and
// decimated, length-bounded AXI-Stream frame generator for the PDH loop.
module pdh_frame_core #(
   parameter int ADC_W      = 14,
   parameter int DATA_W     = 16,
   parameter int ADC_INVERT = 1,
   parameter int DECIM_W    = 16,
   parameter int LEN_W      = 20
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic [ADC_W-1:0]    adc_a_i,
   input  logic [ADC_W-1:0]    adc_b_i,
   input  logic [31:0]         gpio_i,
   output logic [31:0]         gpio_o,
   output logic [4*DATA_W-1:0] m_tdata,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                m_tlast,
   output logic                busy_o,
   output logic [7:0]          led_o
);

   localparam logic [3:0] CMD_NOP       = 4'd0;
   localparam logic [3:0] CMD_SET_LED   = 4'd1;
   localparam logic [3:0] CMD_SET_COEF  = 4'd2;
   localparam logic [3:0] CMD_COMMIT    = 4'd3;
   localparam logic [3:0] CMD_SET_DECIM = 4'd4;
   localparam logic [3:0] CMD_SET_LEN   = 4'd5;
   localparam logic [3:0] CMD_START     = 4'd6;
   localparam logic [3:0] CMD_ABORT     = 4'd7;
   localparam logic [3:0] CMD_STATUS    = 4'd8;
   localparam logic [3:0] CMD_READ_IQ   = 4'd9;

   localparam logic signed [2*DATA_W:0] SAT_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W:0] SAT_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] COEF_ONE = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [ADC_W:0]    ADC_MID  = {2'b01, {(ADC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t state;

   logic strb_meta, strb_sync, strb_prev, strb_rise;
   logic        exec_q;
   logic [3:0]  cmd_q;
   logic [25:0] data_q;

   logic signed [DATA_W-1:0] cos_sh, sin_sh, cos_act, sin_act;
   logic signed [DATA_W-1:0] coef_wr, cos_new, sin_new;
   logic signed [ADC_W:0]    a_off, b_off, a_conv, b_conv;
   logic signed [DATA_W-1:0] sample_a, sample_b;
   logic signed [2*DATA_W-1:0] p_ca, p_sb, p_sa, p_cb;
   logic signed [2*DATA_W:0]   sum_i, sum_q, sh_i, sh_q;
   logic signed [DATA_W-1:0] i_next, q_next, i_q, q_q;

   logic [DECIM_W-1:0] decim, decim_cnt, decim_wr;
   logic [LEN_W-1:0]   len, sample_cnt;
   logic [15:0]        overflow_cnt;
   logic [7:0]         frame_cnt;
   logic               ovf_sticky;
   logic               due, handshake, out_free, last_sample, len_err;
   logic               unused_bits;

   assign unused_bits = ^{gpio_i[31], data_q};
   assign busy_o      = (state != ST_IDLE);

   // The strobe is asynchronous to clk: synchronise, then act only on its rising edge.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         strb_meta <= 1'b0;
         strb_sync <= 1'b0;
         strb_prev <= 1'b0;
         exec_q    <= 1'b0;
         cmd_q     <= '0;
         data_q    <= '0;
      end else begin
         strb_meta <= gpio_i[30];
         strb_sync <= strb_meta;
         strb_prev <= strb_sync;
         exec_q    <= strb_rise;
         if (strb_rise) begin
            cmd_q  <= gpio_i[29:26];
            data_q <= gpio_i[25:0];
         end
      end
   end

   assign strb_rise = strb_sync & ~strb_prev;

   always_comb begin
      a_off = $signed({1'b0, adc_a_i}) - ADC_MID;
      b_off = $signed({1'b0, adc_b_i}) - ADC_MID;
      if (ADC_INVERT != 0) begin
         a_conv = -a_off;
         b_conv = -b_off;
      end else begin
         a_conv = a_off;
         b_conv = b_off;
      end
      sample_a = DATA_W'(a_conv);
      sample_b = DATA_W'(b_conv);
   end

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [2*DATA_W:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[DATA_W-1:0];
      else
         return v[DATA_W-1:0];
   endfunction

   always_comb begin
      sum_i  = (2*DATA_W+1)'(p_ca) - (2*DATA_W+1)'(p_sb);
      sum_q  = (2*DATA_W+1)'(p_sa) + (2*DATA_W+1)'(p_cb);
      sh_i   = sum_i >>> (DATA_W-1);
      sh_q   = sum_q >>> (DATA_W-1);
      i_next = sat_data(sh_i);
      q_next = sat_data(sh_q);
   end

   // Two-stage rotator: products, then scaled and saturated I/Q.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         p_ca <= '0;
         p_sb <= '0;
         p_sa <= '0;
         p_cb <= '0;
         i_q  <= '0;
         q_q  <= '0;
      end else begin
         p_ca <= cos_act * sample_a;
         p_sb <= sin_act * sample_b;
         p_sa <= sin_act * sample_a;
         p_cb <= cos_act * sample_b;
         i_q  <= i_next;
         q_q  <= q_next;
      end
   end

   always_comb begin
      coef_wr     = DATA_W'($signed(data_q[15:0]));
      sin_new     = data_q[16] ? coef_wr : sin_sh;
      cos_new     = data_q[16] ? cos_sh : coef_wr;
      decim_wr    = (data_q[DECIM_W-1:0] == '0) ? DECIM_W'(1) : data_q[DECIM_W-1:0];
      len_err     = busy_o || (data_q[LEN_W-1:0] == '0);
      due         = (decim_cnt == decim - 1'b1);
      handshake   = m_tvalid & m_tready;
      out_free    = ~m_tvalid | m_tready;
      last_sample = (sample_cnt == len - 1'b1);
   end

   // Frame FSM and command execution; a command in the same cycle overrides the FSM.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         gpio_o       <= '0;
         led_o        <= '0;
         m_tdata      <= '0;
         m_tvalid     <= 1'b0;
         m_tlast      <= 1'b0;
         cos_sh       <= COEF_ONE;
         sin_sh       <= '0;
         cos_act      <= COEF_ONE;
         sin_act      <= '0;
         decim        <= DECIM_W'(1);
         len          <= LEN_W'(1024);
         decim_cnt    <= '0;
         sample_cnt   <= '0;
         overflow_cnt <= '0;
         ovf_sticky   <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         case (state)
            ST_CAPTURE: begin
               decim_cnt <= due ? '0 : decim_cnt + 1'b1;
               if (due && out_free) begin
                  m_tdata    <= {i_q, q_q, cos_act, sin_act};
                  m_tvalid   <= 1'b1;
                  m_tlast    <= last_sample;
                  sample_cnt <= sample_cnt + 1'b1;
                  if (last_sample)
                     state <= ST_FLUSH;
               end else begin
                  if (handshake) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                  end
                  if (due) begin
                     if (overflow_cnt != 16'hFFFF)
                        overflow_cnt <= overflow_cnt + 1'b1;
                     ovf_sticky <= 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               if (handshake) begin
                  m_tvalid  <= 1'b0;
                  m_tlast   <= 1'b0;
                  state     <= ST_IDLE;
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
            default: ;
         endcase

         if (exec_q) begin
            case (cmd_q)
               CMD_NOP: gpio_o <= '0;
               CMD_SET_LED: begin
                  led_o  <= data_q[7:0];
                  gpio_o <= {cmd_q, 20'b0, data_q[7:0]};
               end
               CMD_SET_COEF: begin
                  sin_sh <= sin_new;
                  cos_sh <= cos_new;
                  gpio_o <= {cmd_q, sin_new[DATA_W-1 -: 14], cos_new[DATA_W-1 -: 14]};
               end
               CMD_COMMIT: begin
                  cos_act <= cos_sh;
                  sin_act <= sin_sh;
                  gpio_o  <= {cmd_q, 28'd0};
               end
               CMD_SET_DECIM: begin
                  if (!busy_o)
                     decim <= decim_wr;
                  gpio_o <= {cmd_q, 28'(busy_o ? decim : decim_wr)};
               end
               CMD_SET_LEN: begin
                  if (!len_err)
                     len <= data_q[LEN_W-1:0];
                  gpio_o <= {cmd_q, 28'({len_err, 5'b0, (len_err ? len : data_q[LEN_W-1:0])})};
               end
               CMD_START: begin
                  if (!busy_o) begin
                     state        <= ST_CAPTURE;
                     decim_cnt    <= '0;
                     sample_cnt   <= '0;
                     overflow_cnt <= '0;
                     ovf_sticky   <= 1'b0;
                  end
                  gpio_o <= {cmd_q, 1'b0, busy_o, 25'b0, 1'b1};
               end
               CMD_ABORT: begin
                  state    <= ST_IDLE;
                  m_tvalid <= 1'b0;
                  m_tlast  <= 1'b0;
                  gpio_o   <= {cmd_q, 28'd0};
               end
               CMD_STATUS:
                  gpio_o <= {cmd_q, 1'b0, state, ovf_sticky, frame_cnt, overflow_cnt};
               CMD_READ_IQ:
                  gpio_o <= {cmd_q, 2'b0, i_q[DATA_W-1 -: 13], q_q[DATA_W-1 -: 13]};
               default: gpio_o <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pdh_frame_core.sv
// Directed testbench for pdh_frame_core: commands, rotator, frame flow control,
// error responses, reset and abort.
module tb_pdh_frame_core;

   localparam int ADC_W  = 14;
   localparam int DATA_W = 16;

   logic                clk = 1'b0;
   logic                rst_i;
   logic [ADC_W-1:0]    adc_a_i, adc_b_i;
   logic [31:0]         gpio_i;
   logic [31:0]         gpio_o;
   logic [4*DATA_W-1:0] m_tdata;
   logic                m_tvalid, m_tready, m_tlast, busy_o;
   logic [7:0]          led_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pdh_frame_core #(
      .ADC_W(ADC_W), .DATA_W(DATA_W), .ADC_INVERT(1), .DECIM_W(16), .LEN_W(20)
   ) dut (
      .clk(clk), .rst_i(rst_i), .adc_a_i(adc_a_i), .adc_b_i(adc_b_i),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .busy_o(busy_o), .led_o(led_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Strobe low long enough to re-arm the edge detector, then strobe until the command has executed.
   task automatic apply_stimulus(input logic [3:0] cmd, input logic [25:0] data);
      gpio_i[30] = 1'b0;
      repeat (3) tick();
      gpio_i = {1'b0, 1'b1, cmd, data};
      repeat (4) tick();
      gpio_i[30] = 1'b0;
   endtask

   task automatic count_frame(output int beats, output logic [31:0] first_lo);
      beats    = 0;
      first_lo = '0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_tvalid && m_tready) begin
            if (beats == 0) first_lo = m_tdata[31:0];
            beats++;
            if (m_tlast) break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int beats, cyc, prev_cyc, accepted;
      logic done;
      logic [31:0] first_lo;
      logic [63:0] held;

      rst_i    = 1'b1;
      gpio_i   = '0;
      adc_a_i  = '0;
      adc_b_i  = '0;
      m_tready = 1'b1;
      repeat (3) tick();
      check_output("rst_gpio", gpio_o, 32'h0);
      check_output("rst_led", led_o, 8'h0);
      check_output("rst_tvalid", m_tvalid, 1'b0);
      check_output("rst_tlast", m_tlast, 1'b0);
      check_output("rst_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      tick();

      // Held strobe: later data on the still-high strobe must not be re-latched.
      gpio_i = {1'b0, 1'b1, 4'd1, 26'h00000A5};
      repeat (4) tick();
      gpio_i = {1'b0, 1'b1, 4'd1, 26'h000005A};
      repeat (46) tick();
      check_output("t1_led_once", led_o, 8'hA5);
      check_output("t1_cb_led", gpio_o, 32'h100000A5);
      apply_stimulus(4'd0, 26'h0);
      check_output("t1_cb_nop", gpio_o, 32'h0);

      adc_a_i = 14'd0;
      adc_b_i = 14'd8192;
      repeat (2) tick();
      apply_stimulus(4'd9, 26'h0);
      check_output("t2_iq_default", gpio_o, 32'h907FE000);
      apply_stimulus(4'd2, 26'h0000000);
      apply_stimulus(4'd2, 26'h0017FFF);
      check_output("t2_cb_coef", gpio_o, 32'h27FFC000);
      apply_stimulus(4'd9, 26'h0);
      check_output("t2_iq_precommit", gpio_o, 32'h907FE000);
      apply_stimulus(4'd3, 26'h0);
      check_output("t2_cb_commit", gpio_o, 32'h30000000);
      apply_stimulus(4'd9, 26'h0);
      check_output("t2_iq_rotated", gpio_o, 32'h900003FF);

      apply_stimulus(4'd4, 26'd4);
      check_output("t3_cb_decim", gpio_o, 32'h40000004);
      apply_stimulus(4'd5, 26'd8);
      check_output("t3_cb_len", gpio_o, 32'h50000008);
      apply_stimulus(4'd6, 26'h0);
      check_output("t3_cb_start", gpio_o, 32'h60000001);
      check_output("t3_busy", busy_o, 1'b1);
      beats = 0;
      cyc = 0;
      prev_cyc = 0;
      for (int i = 0; i < 100 && beats < 8; i++) begin
         tick();
         cyc++;
         if (m_tvalid && m_tready) begin
            beats++;
            if (beats > 1) check_output("t3_spacing", 64'(cyc - prev_cyc), 64'd4);
            check_output("t3_tlast", m_tlast, (beats == 8));
            prev_cyc = cyc;
         end
      end
      check_output("t3_beats", 64'(beats), 64'd8);
      tick();
      check_output("t3_busy_fall", busy_o, 1'b0);
      apply_stimulus(4'd8, 26'h0);
      check_output("t3_status", gpio_o, 32'h80010000);

      apply_stimulus(4'd4, 26'd1);
      check_output("t4_cb_decim", gpio_o, 32'h40000001);
      apply_stimulus(4'd5, 26'd16);
      check_output("t4_cb_len", gpio_o, 32'h50000010);
      m_tready = 1'b0;
      apply_stimulus(4'd6, 26'h0);
      tick();
      check_output("t4_first_valid", m_tvalid, 1'b1);
      held = m_tdata;
      for (int i = 0; i < 10; i++) begin
         adc_a_i = 14'(1000 * i + 123);
         tick();
      end
      check_output("t4_held_data", m_tdata, held);
      check_output("t4_held_valid", m_tvalid, 1'b1);
      m_tready = 1'b1;
      accepted = 0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (m_tvalid && m_tready) begin
            accepted++;
            done = m_tlast;
         end
         tick();
      end
      check_output("t4_accepted", 64'(accepted), 64'd16);
      check_output("t4_busy_fall", busy_o, 1'b0);
      apply_stimulus(4'd8, 26'h0);
      check_output("t4_status", gpio_o, 32'h8102000A);

      apply_stimulus(4'd4, 26'd0);
      check_output("t5_decim_zero", gpio_o, 32'h40000001);
      apply_stimulus(4'd4, 26'd4);
      apply_stimulus(4'd5, 26'd8);
      apply_stimulus(4'd6, 26'h0);
      apply_stimulus(4'd6, 26'h0);
      check_output("t5_start_busy", gpio_o, 32'h64000001);
      for (int i = 0; i < 300 && busy_o; i++) tick();
      check_output("t5_frame_done", busy_o, 1'b0);
      apply_stimulus(4'd5, 26'd0);
      check_output("t5_len_zero", gpio_o, 32'h52000008);
      apply_stimulus(4'd8, 26'h0);
      check_output("t5_status", gpio_o, 32'h80030000);

      apply_stimulus(4'd6, 26'h0);
      repeat (5) tick();
      check_output("t6_busy_pre_rst", busy_o, 1'b1);
      rst_i = 1'b1;
      #1;
      check_output("t6_rst_tvalid", m_tvalid, 1'b0);
      check_output("t6_rst_tlast", m_tlast, 1'b0);
      check_output("t6_rst_busy", busy_o, 1'b0);
      tick();
      rst_i = 1'b0;
      tick();
      apply_stimulus(4'd5, 26'd4);
      apply_stimulus(4'd6, 26'h0);
      count_frame(beats, first_lo);
      check_output("t6_rst_beats", 64'(beats), 64'd4);
      check_output("t6_rst_coef", first_lo, 32'h7FFF0000);
      tick();

      apply_stimulus(4'd2, 26'h0004000);
      apply_stimulus(4'd2, 26'h001C000);
      apply_stimulus(4'd3, 26'h0);
      apply_stimulus(4'd4, 26'd4);
      apply_stimulus(4'd5, 26'd8);
      apply_stimulus(4'd6, 26'h0);
      repeat (6) tick();
      apply_stimulus(4'd7, 26'h0);
      check_output("t6_abort_cb", gpio_o, 32'h70000000);
      check_output("t6_abort_tvalid", m_tvalid, 1'b0);
      check_output("t6_abort_tlast", m_tlast, 1'b0);
      check_output("t6_abort_busy", busy_o, 1'b0);
      apply_stimulus(4'd8, 26'h0);
      check_output("t6_abort_status", gpio_o, 32'h80010000);
      apply_stimulus(4'd4, 26'd1);
      apply_stimulus(4'd5, 26'd4);
      apply_stimulus(4'd6, 26'h0);
      count_frame(beats, first_lo);
      check_output("t6_abort_beats", 64'(beats), 64'd4);
      check_output("t6_abort_coef", first_lo, 32'h4000C000);
      tick();
      apply_stimulus(4'd8, 26'h0);
      check_output("t6_final_status", gpio_o, 32'h80020000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
